mc_control_fsm: RTL and testbench

- Multi-cycle MIPS main controller. It drives the control side of the ALU interface (ALUop, calCode) and every datapath/memory enable.
- It steps each instruction through fetch, decode, execute, memory and writeback states.
- It sits between the instruction register (opcode/funct) and the shared-memory multi-cycle datapath.
- Memory accesses use a request/ready handshake.

---
 rtl/mc_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable plus the ALU function code.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [3:0] ALUop,
    output logic [5:0] calCode,
    output logic [3:0] state_o,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_IMM_EXEC = 4'd11,
        S_IMM_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] CC_ADD = 6'b100000;
    localparam logic [5:0] CC_SUB = 6'b100010;
    localparam logic [5:0] CC_OR  = 6'b100101;

    state_t state, state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = S_FETCH;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        ALUop      = 4'b0000;
        calCode    = 6'b000000;
        illegal    = 1'b0;

        case (state)
            S_RESET: state_nx = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed alongside the read so PC and IR load together
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                calCode   = CC_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_nx = S_DECODE;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                calCode   = CC_ADD;
                case (opcode)
                    OP_RTYPE:        state_nx = S_EXEC;
                    OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
                    OP_BEQ:          state_nx = S_BRANCH;
                    OP_ADDIU, OP_ORI: state_nx = S_IMM_EXEC;
                    OP_J:            state_nx = S_JUMP;
                    default: begin
                        illegal  = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                calCode   = CC_ADD;
                state_nx  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_nx = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_nx  = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                calCode   = funct;
                state_nx  = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                calCode   = CC_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_ORI) begin
                    calCode  = CC_OR;
                    ext_zero = 1'b1;
                end else begin
                    calCode  = CC_ADD;
                end
                state_nx = S_IMM_WB;
            end
            S_IMM_WB: reg_write = 1'b1;
            default:  state_nx = S_FETCH;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm; a per-instruction state-path model predicts
// the state and every output each cycle.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] ALUop;
    logic [5:0] calCode;
    logic [3:0] state_o;
    logic       illegal;

    int ncmp = 0;
    int nerr = 0;
    int ms   = 0;     // model state number
    int path[$];      // remaining states of the current instruction

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .ALUop(ALUop), .calCode(calCode), .state_o(state_o), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] dut_vec();
        return {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, ALUop, calCode,
                illegal};
    endfunction

    // Expected outputs written straight from the per-state output table
    function automatic logic [24:0] ref_vec(int st, logic [5:0] op, logic [5:0] fn,
                                            logic z, logic mr);
        logic rd = 0, wr = 0, ad = 0, irw = 0, pcw = 0, rw = 0, rdst = 0, m2r = 0;
        logic sa = 0, ez = 0, ill = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [5:0] cc = 0;
        case (st)
            1:  begin rd = 1; sb = 2'b01; cc = 6'b100000; irw = mr; pcw = mr; end
            2:  begin sb = 2'b11; cc = 6'b100000;
                      ill = !(op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd9, 6'd13, 6'd2}); end
            3:  begin sa = 1; sb = 2'b10; cc = 6'b100000; end
            4:  begin rd = 1; ad = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin wr = 1; ad = 1; end
            7:  begin sa = 1; cc = fn; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin sa = 1; cc = 6'b100010; ps = 2'b01; pcw = z; end
            10: begin pcw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10;
                      if (op == 6'd13) begin cc = 6'b100101; ez = 1; end
                      else cc = 6'b100000; end
            12: rw = 1;
            default: ;
        endcase
        return {rd, wr, ad, irw, pcw, ps, rw, rdst, m2r, sa, sb, ez, 4'b0000, cc, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h (model state %0d)", tag, got, exp, ms);
        end
    endtask

    task automatic check_now();
        chk("state", {28'd0, state_o}, ms);
        chk("outputs", {7'd0, dut_vec()}, {7'd0, ref_vec(ms, opcode, funct, zero, mem_ready)});
    endtask

    task automatic model_step();
        if (rst) begin
            ms = 0;
            path.delete();
        end else if (ms == 0) begin
            ms = 1;
        end else if ((ms == 1 || ms == 4 || ms == 6) && !mem_ready) begin
            ms = ms;
        end else if (ms == 1) begin
            case (opcode)
                6'd0:        path = '{2, 7, 8};
                6'd35:       path = '{2, 3, 4, 5};
                6'd43:       path = '{2, 3, 6};
                6'd4:        path = '{2, 9};
                6'd2:        path = '{2, 10};
                6'd9, 6'd13: path = '{2, 11, 12};
                default:     path = '{2};
            endcase
            ms = path.pop_front();
        end else if (path.size() > 0) begin
            ms = path.pop_front();
        end else begin
            ms = 1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_now();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH; fw/dw are ready-low cycles
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int dw);
        int prev;
        bit done = 0;
        opcode = op; funct = fn; zero = z;
        for (int n = 0; n < 60 && !done; n++) begin
            if (ms == 1) begin
                if (fw > 0) begin mem_ready = 0; fw--; end else mem_ready = 1;
            end else if (ms == 4 || ms == 6) begin
                if (dw > 0) begin mem_ready = 0; dw--; end else mem_ready = 1;
            end else begin
                mem_ready = $urandom_range(0, 1);
            end
            prev = ms;
            cyc();
            if (ms == 1 && prev != 1 && prev != 0) done = 1;
        end
        chk("instr_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int ops[9] = '{0, 35, 43, 4, 9, 13, 2, 63, 5};
        rst = 1; opcode = 0; funct = 6'b100010; zero = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_now();                          // reset state, all outputs zero
        rst = 0;
        cyc();                                // RESET -> FETCH
        chk("after_reset_fetch", {28'd0, state_o}, 32'd1);

        run_instr(6'd0,  6'b100010, 0, 0, 0); // R-type SUB
        run_instr(6'd35, 6'd0, 0, 0, 3);      // lw with 3 wait cycles in MEM_RD
        run_instr(6'd4,  6'd0, 1, 0, 0);      // beq taken
        run_instr(6'd4,  6'd0, 0, 0, 0);      // beq not taken
        run_instr(6'd13, 6'd0, 0, 1, 0);      // ori
        run_instr(6'd63, 6'd0, 0, 0, 0);      // illegal opcode
        run_instr(6'd43, 6'd0, 0, 2, 2);      // sw
        run_instr(6'd2,  6'd0, 0, 0, 0);      // j

        // Asynchronous reset while a store is waiting
        opcode = 6'd43; mem_ready = 1;
        for (int n = 0; n < 10 && ms != 6; n++) cyc();
        chk("reached_mem_wr", {28'd0, state_o}, 32'd6);
        mem_ready = 0;
        cyc(); cyc();
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_state", {28'd0, state_o}, 32'd0);
        chk("async_rst_outputs", {7'd0, dut_vec()}, 32'd0);
        @(posedge clk);
        model_step();
        #1 rst = 0;
        repeat (4) cyc();                     // RESET, then FETCH held with ready low
        chk("post_rst_no_write", {31'd0, mem_write}, 32'd0);
        run_instr(6'd9, 6'd0, 0, 0, 0);       // addiu

        for (int i = 0; i < 80; i++)
            run_instr(ops[$urandom_range(0, 8)], 6'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
